// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that shares a registered 3-input mux among three requesters.
// Drives select/grant, bounds each tenure with a burst counter, and tags the mux output one cycle later.
module mux_sel_arbiter #(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       out_valid,
  output logic [1:0] out_owner
);

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OWN_W   = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam bit USE_GAP = (TURNAROUND != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [OWN_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OWN_W-1:0]     select_q, select_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [OWN_W-1:0]     out_owner_q, out_owner_d;

  logic                 win_vld_c;
  logic [OWN_W-1:0]     win_idx_c;
  logic                 owner_req_c;
  logic                 release_c;

  // Rotation: search starts just after the last owner, so the last owner has lowest priority.
  always_comb begin
    win_vld_c = |req;
    win_idx_c = '0;
    case (last_q)
      2'd0: begin
        if (req[1])      win_idx_c = 2'd1;
        else if (req[2]) win_idx_c = 2'd2;
        else             win_idx_c = 2'd0;
      end
      2'd1: begin
        if (req[2])      win_idx_c = 2'd2;
        else if (req[0]) win_idx_c = 2'd0;
        else             win_idx_c = 2'd1;
      end
      default: begin
        if (req[0])      win_idx_c = 2'd0;
        else if (req[1]) win_idx_c = 2'd1;
        else             win_idx_c = 2'd2;
      end
    endcase
  end

  // Owner keeps its request iff its grant bit still sees req; burst ends on the last allowed cycle.
  always_comb begin
    owner_req_c = |(req & grant_q);
    release_c   = !owner_req_c || (count_q == LAST_CNT);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    count_d     = count_q;
    grant_d     = grant_q;
    select_d    = select_q;
    busy_d      = busy_q;
    out_valid_d = busy_q;
    out_owner_d = busy_q ? last_q : out_owner_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_vld_c) begin
          state_d  = ST_GRANT;
          last_d   = win_idx_c;
          count_d  = '0;
          grant_d  = NUM_REQ'(3'b001 << win_idx_c);
          select_d = win_idx_c + 2'd1;
          busy_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          count_d  = '0;
          grant_d  = '0;
          select_d = '0;
          busy_d   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!release_c) begin
          count_d = count_q + CNT_W'(1);
        end else if (USE_GAP) begin
          state_d  = ST_GAP;
          count_d  = '0;
          grant_d  = '0;
          select_d = '0;
          busy_d   = 1'b0;
        end else if (win_vld_c) begin
          state_d  = ST_GRANT;
          last_d   = win_idx_c;
          count_d  = '0;
          grant_d  = NUM_REQ'(3'b001 << win_idx_c);
          select_d = win_idx_c + 2'd1;
          busy_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          count_d  = '0;
          grant_d  = '0;
          select_d = '0;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        count_d  = '0;
        grant_d  = '0;
        select_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset points last owner at 2 so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'd2;
      count_q     <= '0;
      grant_q     <= '0;
      select_q    <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_owner_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      count_q     <= count_d;
      grant_q     <= grant_d;
      select_q    <= select_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_owner_q <= out_owner_d;
    end
  end

  assign grant     = grant_q;
  assign select    = select_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_owner = out_owner_q;

  // Structural invariants of the grant/select outputs.
  a_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(grant_q));
  a_sel_busy: assert property (@(posedge clock) disable iff (!reset_n) ((select_q != 2'd0) == busy_q));
  a_sel_stable: assert property (@(posedge clock) disable iff (!reset_n)
    (busy_q && state_d == ST_GRANT && count_d != '0) |=> $stable(select_q));

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: three configurations (4/gap, 4/no-gap, 1/no-gap) checked against a tenure-level model.
module tb_mux_sel_arbiter;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [2:0] req_v      [3];
  logic [2:0] grant_v    [3];
  logic [1:0] select_v   [3];
  logic       busy_v     [3];
  logic       out_valid_v[3];
  logic [1:0] out_owner_v[3];

  mux_sel_arbiter #(.BURST_LEN(4), .TURNAROUND(1)) u_a (
    .clock(clock), .reset_n(reset_n), .req(req_v[0]), .grant(grant_v[0]), .select(select_v[0]),
    .busy(busy_v[0]), .out_valid(out_valid_v[0]), .out_owner(out_owner_v[0]));
  mux_sel_arbiter #(.BURST_LEN(4), .TURNAROUND(0)) u_b (
    .clock(clock), .reset_n(reset_n), .req(req_v[1]), .grant(grant_v[1]), .select(select_v[1]),
    .busy(busy_v[1]), .out_valid(out_valid_v[1]), .out_owner(out_owner_v[1]));
  mux_sel_arbiter #(.BURST_LEN(1), .TURNAROUND(0)) u_c (
    .clock(clock), .reset_n(reset_n), .req(req_v[2]), .grant(grant_v[2]), .select(select_v[2]),
    .busy(busy_v[2]), .out_valid(out_valid_v[2]), .out_owner(out_owner_v[2]));

  localparam int BL [3] = '{4, 4, 1};
  localparam int TA [3] = '{1, 0, 0};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner index or -1, granted cycles completed in the tenure, last owner, output tag.
  int m_owner[3];
  int m_cnt  [3];
  int m_last [3];
  int m_vown [3];
  bit m_vld  [3];

  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_owner[i] = -1; m_cnt[i] = 0; m_last[i] = 2; m_vld[i] = 1'b0; m_vown[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int w;
        bit rel;
        m_vld[i] = (m_owner[i] >= 0);
        if (m_vld[i]) m_vown[i] = m_owner[i];
        if (m_owner[i] >= 0) begin
          rel = !req_v[i][m_owner[i]] || (m_cnt[i] + 1 == BL[i]);
          if (!rel) m_cnt[i]++;
          else if (TA[i] != 0) m_owner[i] = -1;
          else begin
            w = pick(req_v[i], m_last[i]);
            m_owner[i] = w; m_cnt[i] = 0;
            if (w >= 0) m_last[i] = w;
          end
        end else begin
          w = pick(req_v[i], m_last[i]);
          if (w >= 0) begin
            m_owner[i] = w; m_cnt[i] = 0; m_last[i] = w;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      int eg, es;
      eg = (m_owner[i] < 0) ? 0 : (1 << m_owner[i]);
      es = m_owner[i] + 1;
      chk($sformatf("grant[%0d]", i), 32'(grant_v[i]), 32'(eg));
      chk($sformatf("select[%0d]", i), 32'(select_v[i]), 32'(es));
      chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_owner[i] >= 0));
      chk($sformatf("out_valid[%0d]", i), 32'(out_valid_v[i]), 32'(m_vld[i]));
      if (m_vld[i]) chk($sformatf("out_owner[%0d]", i), 32'(out_owner_v[i]), 32'(m_vown[i]));
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_all(input int n);
    for (int i = 0; i < 3; i++) req_v[i] = 3'b000;
    repeat (n) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) req_v[i] = 3'b000;
    repeat (3) @(negedge clock);
    chk("rst_grant_a", 32'(grant_v[0]), 32'd0);
    chk("rst_outv_a", 32'(out_valid_v[0]), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single requester with gap, full rotation without gap, and BURST_LEN=1 alternation.
    req_v[0] = 3'b001; req_v[1] = 3'b111; req_v[2] = 3'b101;
    for (int t = 1; t <= 14; t++) begin
      tick();
      case (t)
        1: begin
          chk("t1_grant_a", 32'(grant_v[0]), 32'd1);
          chk("t1_select_a", 32'(select_v[0]), 32'd1);
          chk("t1_outv_a", 32'(out_valid_v[0]), 32'd0);
          chk("t5_grant_c0", 32'(grant_v[2]), 32'd1);
        end
        2: begin
          chk("t1_outv_a2", 32'(out_valid_v[0]), 32'd1);
          chk("t1_outown_a2", 32'(out_owner_v[0]), 32'd0);
          chk("t5_grant_c1", 32'(grant_v[2]), 32'd4);
        end
        3: begin
          chk("t5_grant_c2", 32'(grant_v[2]), 32'd1);
          chk("t5_outown_c2", 32'(out_owner_v[2]), 32'd2);
        end
        5: begin
          chk("t1_gap_a", 32'(grant_v[0]), 32'd0);
          chk("t1_gap_outv_a", 32'(out_valid_v[0]), 32'd1);
          chk("t2_select_b1", 32'(select_v[1]), 32'd2);
        end
        6: chk("t1_regrant_a", 32'(grant_v[0]), 32'd1);
        9: chk("t2_select_b2", 32'(select_v[1]), 32'd3);
        13: begin
          chk("t2_select_b3", 32'(select_v[1]), 32'd1);
          chk("t2_busy_b3", 32'(busy_v[1]), 32'd1);
        end
        default: ;
      endcase
    end
    idle_all(4);

    // Owner 1 drops request after two granted cycles while requester 2 waits.
    req_v[0] = 3'b110;
    tick();
    chk("t3_select1", 32'(select_v[0]), 32'd2);
    tick();
    req_v[0] = 3'b100;
    tick();
    chk("t3_gap", 32'(grant_v[0]), 32'd0);
    tick();
    chk("t3_grant2", 32'(grant_v[0]), 32'd4);
    chk("t3_select2", 32'(select_v[0]), 32'd3);
    idle_all(3);

    // Request drop coincides with burst expiry: one release, one gap.
    req_v[0] = 3'b011;
    tick();
    chk("t4_grant0", 32'(grant_v[0]), 32'd1);
    repeat (3) tick();
    req_v[0] = 3'b010;
    tick();
    chk("t4_gap", 32'(grant_v[0]), 32'd0);
    tick();
    chk("t4_grant1", 32'(grant_v[0]), 32'd2);
    tick();
    chk("t4_hold1", 32'(grant_v[0]), 32'd2);
    idle_all(3);

    // Asynchronous reset during owner 2's tenure.
    req_v[0] = 3'b100;
    repeat (2) tick();
    chk("t6_pre_grant", 32'(grant_v[0]), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant_v[0]), 32'd0);
    chk("t6_rst_select", 32'(select_v[0]), 32'd0);
    chk("t6_rst_outv", 32'(out_valid_v[0]), 32'd0);
    req_v[0] = 3'b111;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("t6_first_grant", 32'(grant_v[0]), 32'd1);
    chk("t6_first_select", 32'(select_v[0]), 32'd1);
    idle_all(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
